mul16_overlap_writer: RTL and testbench

Sequential 16x16 unsigned shift-add multiplier core for the mul16_16cycle datapath. Each iteration reads the 16-bit accumulator window at bit offset clk1 and adds the multiplicand when multiplier bit b[clk1] is set. The 17-bit sum is written back into the accumulator at the same offset: acc[clk1+16:clk1]. It takes 16 iterations, one per clock, with a start/busy/done handshake.

---
 rtl/mul16_overlap_writer.sv | 91 +++++++++
 tb/tb_mul16_overlap_writer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mul16_overlap_writer.sv
// rtl/mul16_overlap_writer.sv - sequential 16x16 unsigned shift-add multiplier
// Each RUN cycle adds a 16-bit addend into a 17-bit window of acc at offset clk1.
module mul16_overlap_writer #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic [3:0]     clk1
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [2*N-1:0]   acc_q, acc_d;
  logic [3:0]       clk1_q, clk1_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;

  logic [N-1:0]     window;
  logic [N-1:0]     addend;
  logic [N:0]       sum17;
  logic [2*N-1:0]   wr_mask;
  logic [2*N-1:0]   wr_data;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    clk1_d  = clk1_q;
    a_d     = a_q;
    b_d     = b_q;

    window  = acc_q[clk1_q +: N];
    addend  = b_q[clk1_q] ? a_q : '0;
    sum17   = {1'b0, window} + {1'b0, addend};
    // The 17-bit write never leaves acc: at clk1=15 it lands exactly on acc[31:15].
    wr_mask = {{(N-1){1'b0}}, {(N+1){1'b1}}} << clk1_q;
    wr_data = {{(N-1){1'b0}}, sum17} << clk1_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          clk1_d  = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d = (acc_q & ~wr_mask) | wr_data;
        if (clk1_q == 4'd15) begin
          clk1_d  = '0;
          state_d = S_DONE;
        end else begin
          clk1_d = clk1_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      clk1_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      clk1_q  <= clk1_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign product = acc_q;
  assign clk1    = clk1_q;

endmodule

// File: tb/tb_mul16_overlap_writer.sv
// tb/tb_mul16_overlap_writer.sv - directed and random checks for mul16_overlap_writer
module tb_mul16_overlap_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic [3:0]  clk1;

  int checks = 0;
  int errors = 0;

  mul16_overlap_writer #(.N(16)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product), .clk1(clk1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // carry-bit invariant: the bit just above the window is clear before every write
  always @(negedge clk) begin
    if (!rst && busy) begin
      int idx;
      idx = int'(clk1) + 16;
      checks++;
      if (product[idx] !== 1'b0) begin
        errors++;
        $display("FAIL carry_invariant: acc[%0d]=%b at clk1=%0d expected 0", idx, product[idx], clk1);
      end
    end
  end

  // Waits (from just before a posedge) for done; returns the number of rising edges taken.
  task automatic wait_done(output int edges, output int busy_cnt);
    edges = 0;
    busy_cnt = 0;
    while (edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done) break;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic [31:0] exp,
                        input bit full);
    int edges, bc;
    a = va; b = vb; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (full) chk("busy_after_start", 32'(busy), 32'd1);
    wait_done(edges, bc);
    chk("done_latency", edges, 32'd16);
    chk("product", product, exp);
    if (full) begin
      chk("busy_cycles", bc + 1, 32'd16);
      @(posedge clk); @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      repeat (2) begin @(posedge clk); @(negedge clk); end
      chk("idle_hold", product, exp);
      chk("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int edges, bc, seen;
    logic [15:0] ra, rb;

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[2] = '{16'h8000, 16'h8000, 32'h40000000};
    vecs[3] = '{16'h1234, 16'h0000, 32'h00000000};
    vecs[4] = '{16'h0000, 16'hFFFF, 32'h00000000};
    vecs[5] = '{16'h0001, 16'hFFFF, 32'h0000FFFF};
    vecs[6] = '{16'hFFFF, 16'h0001, 32'h0000FFFF};
    vecs[7] = '{16'h00FF, 16'h0101, 32'h0000FFFF};
    vecs[8] = '{16'h1234, 16'h5678, 32'h06260060};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_product", product, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_clk1", 32'(clk1), 32'd0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);

    for (int i = 0; i < 9; i++) run_op(vecs[i].va, vecs[i].vb, vecs[i].exp, 1'b1);

    // start pulsed mid-run with new operands must be ignored
    a = 16'd7; b = 16'd9; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    a = 16'd2; b = 16'd2; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; a = 16'hAAAA; b = 16'h5555;
    seen = 0; edges = 0;
    while (edges < 30) begin
      @(posedge clk); edges++; @(negedge clk);
      if (done) begin
        seen++;
        chk("ignore_start_product", product, 32'h0000003F);
      end
    end
    chk("ignore_start_done_count", seen, 32'd1);

    // reset mid-run discards the operation
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    edges = 0;
    while (clk1 != 4'd8 && edges < 20) begin @(posedge clk); edges++; @(negedge clk); end
    chk("reach_clk1_8", 32'(clk1), 32'd8);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("midrst_product", product, 32'd0);
    chk("midrst_clk1", 32'(clk1), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    seen = 0;
    repeat (20) begin @(posedge clk); @(negedge clk); if (done || busy) seen++; end
    chk("midrst_quiet", seen, 32'd0);
    run_op(16'h0010, 16'h0010, 32'h00000100, 1'b1);

    // back-to-back with start held high
    a = 16'h00FF; b = 16'h0101; start = 1'b1;
    @(posedge clk); @(negedge clk);
    wait_done(edges, bc);
    chk("b2b_first_latency", edges, 32'd16);
    chk("b2b_first_product", product, 32'h0000FFFF);
    a = 16'd2; b = 16'd3;
    @(posedge clk); @(negedge clk);
    chk("b2b_accepted", 32'(busy), 32'd1);
    wait_done(edges, bc);
    start = 1'b0;
    chk("b2b_second_latency", edges + 1, 32'd17);
    chk("b2b_second_product", product, 32'h00000006);
    @(posedge clk); @(negedge clk);
    chk("b2b_idle", 32'(busy | done), 32'd0);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op(ra, rb, 32'(ra) * 32'(rb), 1'b0);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); @(negedge clk); end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
